led_frame_ctrl: RTL and testbench

Frame controller for the 16x16 red/green LED matrix. Sits between game logic and the LED display driver. It holds a back buffer that game logic draws into, and a front buffer that feeds the driver's RedPixels/GrnPixels. It also generates the driver's EnableCount scan pacing and copies back to front only at a frame boundary, so the display never tears.

---
 rtl/led_frame_ctrl_if.sv | 25 ++
 rtl/led_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_led_frame_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_frame_ctrl_if.sv
// rtl/led_frame_ctrl_if.sv - game-logic side of the LED frame controller
// master = game logic, slave = frame controller
interface led_frame_ctrl_if;
  logic [9:0] speed;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [3:0] wr_col;
  logic       wr_red;
  logic       wr_grn;
  logic       clr_req;
  logic       swap_req;
  logic       busy;
  logic       swap_done;
  logic       frame_start;

  modport master (
    output speed, wr_en, wr_row, wr_col, wr_red, wr_grn, clr_req, swap_req,
    input  busy, swap_done, frame_start
  );

  modport slave (
    input  speed, wr_en, wr_row, wr_col, wr_red, wr_grn, clr_req, swap_req,
    output busy, swap_done, frame_start
  );
endinterface

// File: rtl/led_frame_ctrl.sv
// rtl/led_frame_ctrl.sv - double-buffered 16x16 LED frame controller
// Paces the driver scan and copies back to front only on the row 15 -> 0 edge.
module led_frame_ctrl #(
  parameter int FREQDIV = 0
) (
  input  logic              clk,
  input  logic              rst,
  led_frame_ctrl_if.slave   ctl,
  output logic [15:0][15:0] RedPixels,
  output logic [15:0][15:0] GrnPixels,
  output logic              EnableCount
);

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [9:0]          pace_cnt;
  logic [FREQDIV+3:0]  scan_cnt;
  logic                wrap;
  logic                swap_pend;
  logic [3:0]          clr_row;
  logic [15:0][15:0]   back_red;
  logic [15:0][15:0]   back_grn;
  logic                busy;
  logic                do_write;
  logic                do_clear_row;
  logic                do_swap;
  logic                start_clear;
  logic                swap_done_q;
  logic                frame_start_q;

  // Same edge on which the driver moves from row 15 back to row 0.
  assign wrap = EnableCount && (scan_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pace_cnt    <= '0;
      EnableCount <= 1'b0;
    end else if (pace_cnt >= ctl.speed) begin
      pace_cnt    <= '0;
      EnableCount <= 1'b1;
    end else begin
      pace_cnt    <= pace_cnt + 10'd1;
      EnableCount <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      scan_cnt <= '0;
    else if (EnableCount)
      scan_cnt <= scan_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ctl.clr_req)
          state_nxt = CLEAR;
        else if (swap_pend || ctl.swap_req)
          state_nxt = SWAP_WAIT;
      end
      CLEAR:     if (clr_row == 4'd15) state_nxt = IDLE;
      SWAP_WAIT: if (wrap) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = 1'b0;
    do_write     = 1'b0;
    do_clear_row = 1'b0;
    do_swap      = 1'b0;
    start_clear  = 1'b0;
    case (state)
      IDLE: begin
        start_clear = ctl.clr_req;
        do_write    = ctl.wr_en && !ctl.clr_req;
      end
      CLEAR: begin
        busy         = 1'b1;
        do_clear_row = 1'b1;
      end
      SWAP_WAIT: begin
        busy    = 1'b1;
        do_swap = wrap;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      back_red      <= '0;
      back_grn      <= '0;
      RedPixels     <= '0;
      GrnPixels     <= '0;
      clr_row       <= '0;
      swap_pend     <= 1'b0;
      swap_done_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= wrap;
      swap_done_q   <= do_swap;
      // A request landing on the swap edge is satisfied by that swap.
      if (do_swap)
        swap_pend <= 1'b0;
      else if (ctl.swap_req)
        swap_pend <= 1'b1;
      if (start_clear)
        clr_row <= '0;
      else if (do_clear_row)
        clr_row <= clr_row + 4'd1;
      if (do_write) begin
        back_red[ctl.wr_row][ctl.wr_col] <= ctl.wr_red;
        back_grn[ctl.wr_row][ctl.wr_col] <= ctl.wr_grn;
      end
      if (do_clear_row) begin
        back_red[clr_row] <= '0;
        back_grn[clr_row] <= '0;
      end
      if (do_swap) begin
        RedPixels <= back_red;
        GrnPixels <= back_grn;
      end
    end
  end

  assign ctl.busy        = busy;
  assign ctl.swap_done   = swap_done_q;
  assign ctl.frame_start = frame_start_q;

endmodule

// File: tb/tb_led_frame_ctrl.sv
// tb/tb_led_frame_ctrl.sv - randomized and directed bench with a frame-level reference model
module tb_led_frame_ctrl;
  localparam int FREQDIV = 0;
  localparam int FRAME   = 1 << (FREQDIV + 4);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_frame_ctrl_if ifc();
  logic [15:0][15:0] red_pixels;
  logic [15:0][15:0] grn_pixels;
  logic              enable_count;

  led_frame_ctrl #(.FREQDIV(FREQDIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctl         (ifc),
    .RedPixels   (red_pixels),
    .GrnPixels   (grn_pixels),
    .EnableCount (enable_count)
  );

  int checks   = 0;
  int failures = 0;

  // reference model: edge count since reset, buffers, and what the block is busy with
  int                k;
  int                spd;
  int                clear_left;
  bit                waiting;
  bit                pend;
  bit                e_sd;
  bit                e_fs;
  bit [15:0][15:0]   mb_r, mb_g, mf_r, mf_g;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset(input int s);
    k = 0; spd = s; clear_left = 0; waiting = 0; pend = 0; e_sd = 0; e_fs = 0;
    mb_r = '0; mb_g = '0; mf_r = '0; mf_g = '0;
  endtask

  // One scan pulse every spd+1 cycles, 16 pulses per frame; a frame ends on the edge after the 16th pulse.
  task automatic model_edge(input bit w, input bit [3:0] r, input bit [3:0] c,
                            input bit vr, input bit vg, input bit clr, input bit sw);
    bit wrap;
    k++;
    wrap = (k > 1) && (k % (FRAME * (spd + 1)) == 1);
    e_fs = wrap;
    e_sd = 0;
    if (clear_left > 0) begin
      clear_left--;
      if (sw) pend = 1;
    end else if (waiting) begin
      if (wrap) begin
        mf_r = mb_r; mf_g = mb_g; e_sd = 1; waiting = 0; pend = 0;
      end
    end else if (clr) begin
      mb_r = '0; mb_g = '0; clear_left = 16;
      if (sw) pend = 1;
    end else begin
      if (w) begin mb_r[r][c] = vr; mb_g[r][c] = vg; end
      if (pend || sw) begin waiting = 1; pend = 0; end
    end
  endtask

  task automatic compare();
    check("enable_count", enable_count, (k > 0) && (k % (spd + 1) == 0));
    check("busy", ifc.busy, (clear_left > 0) || waiting);
    check("swap_done", ifc.swap_done, e_sd);
    check("frame_start", ifc.frame_start, e_fs);
    check("red_pixels", red_pixels, mf_r);
    check("grn_pixels", grn_pixels, mf_g);
  endtask

  task automatic step(input bit w, input bit [3:0] r, input bit [3:0] c,
                      input bit vr, input bit vg, input bit clr, input bit sw);
    ifc.wr_en = w; ifc.wr_row = r; ifc.wr_col = c; ifc.wr_red = vr; ifc.wr_grn = vg;
    ifc.clr_req = clr; ifc.swap_req = sw;
    @(posedge clk);
    model_edge(w, r, c, vr, vg, clr, sw);
    #1;
    compare();
    ifc.wr_en = 0; ifc.clr_req = 0; ifc.swap_req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_cycles(input int n, input int s);
    ifc.speed = 10'(s);
    rst = 1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_reset(s);
      #1;
      compare();
    end
    rst = 0;
  endtask

  int n_busy;
  int n_sd;
  int at_sd;

  initial begin
    ifc.speed = 10'd3; ifc.wr_en = 0; ifc.wr_row = 0; ifc.wr_col = 0;
    ifc.wr_red = 0; ifc.wr_grn = 0; ifc.clr_req = 0; ifc.swap_req = 0;
    model_reset(3);

    reset_cycles(2, 3);
    idle(140);

    step(1, 4'd2, 4'd3, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(70);

    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 4'd5, 4'd5, 1, 1, 0, 0);
    idle(70);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(70);
    check("back_keeps_2_3", red_pixels[2][3], 1'b1);
    check("dropped_5_5", red_pixels[5][5], 1'b0);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        step(1, 4'(r), 4'(c), 1, 1, 0, 0);
    step(1, 4'd7, 4'd7, 1, 1, 1, 0);
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.busy) n_busy++;
      step(0, 0, 0, 0, 0, 0, 0);
    end
    check("clear_busy_len", n_busy, 16);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(70);
    check("clear_blank", red_pixels | grn_pixels, '0);

    reset_cycles(1, 0);
    n_sd = 0; at_sd = 0;
    for (int i = 1; i <= 40; i++) begin
      step(0, 0, 0, 0, 0, 0, (i == 2) || (i == 5) || (i == 9));
      if (ifc.swap_done) begin n_sd++; at_sd = i; end
    end
    check("merge_count", n_sd, 1);
    check("merge_edge", at_sd, FRAME + 1);

    step(1, 4'd9, 4'd1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    idle(6);
    reset_cycles(1, 0);
    check("rst_clear_busy", ifc.busy, 1'b0);
    check("rst_clear_ec", enable_count, 1'b0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(20);

    for (int round = 0; round < 4; round++) begin
      reset_cycles(2, $urandom_range(0, 3));
      for (int i = 0; i < 500; i++)
        step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 60) == 0, $urandom_range(0, 20) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
